// File: rtl/barrel_seq_shifter.sv
// rtl/barrel_seq_shifter.sv - sequential multi-cycle shift unit with load and start/busy/done handshake
//
// Purpose:
//   Shift register of SIZE bits supporting parallel load and a programmable
//   number of single-bit LSL/LSR/ASR (and optionally ROL/ROR) steps, one per
//   clock, with a serial fill input and a shifted-out bit.
//
// Configuration macro:
//   ROTATE_OPS_EN - when defined, op 011 (ROL) and 100 (ROR) are implemented.
//                   When undefined they behave as reserved ops (zero-length done
//                   pulse, no state change) and no rotate logic is built.
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   load    in   1      parallel load request (idle only, wins over start)
//   pin     in   SIZE   parallel load data
//   start   in   1      begin shift operation (idle only)
//   op      in   3      000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR
//   amount  in   CNT_W  number of single-bit shifts
//   sin     in   1      serial fill bit for LSL/LSR, sampled every shift cycle
//   pout    out  SIZE   register contents
//   sout    out  1      last bit shifted out
//   busy    out  1      shift in progress
//   done    out  1      one-cycle completion pulse

module barrel_seq_shifter #(
    parameter int SIZE  = 10,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIZE-1:0]  pin,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin,
    output logic [SIZE-1:0]  pout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LSL = 3'b000;
    localparam logic [2:0] OP_LSR = 3'b001;
    localparam logic [2:0] OP_ASR = 3'b010;
`ifdef ROTATE_OPS_EN
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [SIZE-1:0]  data_q, data_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic             op_ok;
    logic [SIZE-1:0]  shifted;
    logic             shifted_out;

    // Which incoming op codes start a real shift; everything else completes
    // immediately without touching the register.
    always_comb begin
        op_ok = 1'b0;
        case (op)
            OP_LSL, OP_LSR, OP_ASR: op_ok = 1'b1;
`ifdef ROTATE_OPS_EN
            OP_ROL, OP_ROR:         op_ok = 1'b1;
`endif
            default:                op_ok = 1'b0;
        endcase
    end

    // Single-bit step for the latched op. Only latched ops that passed op_ok
    // ever reach SHIFT, so the default arm is a hold.
    always_comb begin
        shifted     = data_q;
        shifted_out = sout_q;
        case (op_q)
            OP_LSL: begin
                shifted     = {data_q[SIZE-2:0], sin};
                shifted_out = data_q[SIZE-1];
            end
            OP_LSR: begin
                shifted     = {sin, data_q[SIZE-1:1]};
                shifted_out = data_q[0];
            end
            OP_ASR: begin
                shifted     = {data_q[SIZE-1], data_q[SIZE-1:1]};
                shifted_out = data_q[0];
            end
`ifdef ROTATE_OPS_EN
            OP_ROL: begin
                shifted     = {data_q[SIZE-2:0], data_q[SIZE-1]};
                shifted_out = data_q[SIZE-1];
            end
            OP_ROR: begin
                shifted     = {data_q[0], data_q[SIZE-1:1]};
                shifted_out = data_q[0];
            end
`endif
            default: begin
                shifted     = data_q;
                shifted_out = sout_q;
            end
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d = pin;
                end else if (start) begin
                    if ((amount == '0) || !op_ok) begin
                        done_d = 1'b1;
                    end else begin
                        op_d    = op;
                        cnt_d   = amount;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = shifted;
                sout_d = shifted_out;
                cnt_d  = cnt_q - CNT_W'(1);
                // The shift performed now is the last one when one step remains.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_LSL;
            data_q  <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign pout = data_q;
    assign sout = sout_q;
    assign busy = (state_q == SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_barrel_seq_shifter.sv
// tb/tb_barrel_seq_shifter.sv - self-checking bench for barrel_seq_shifter (SIZE=8)

module tb_barrel_seq_shifter;

    localparam int SZ = 8;
    localparam int CW = 4;
`ifdef ROTATE_OPS_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [SZ-1:0] pin = '0;
    logic          start = 1'b0;
    logic [2:0]    op = '0;
    logic [CW-1:0] amount = '0;
    logic          sin = 1'b0;
    logic [SZ-1:0] pout;
    logic          sout;
    logic          busy;
    logic          done;

    int checks = 0;
    int passes = 0;
    int exp_pout = 0;
    int exp_sout = 0;

    barrel_seq_shifter #(.SIZE(SZ), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .load(load), .pin(pin), .start(start), .op(op),
        .amount(amount), .sin(sin), .pout(pout), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: one shift step on an integer value, from the op definitions.
    task automatic model_step(input int o, input int s, inout int v, inout int out);
        case (o)
            0: begin out = v / 128;  v = (v * 2 + s) % 256; end
            1: begin out = v % 2;    v = v / 2 + s * 128; end
            2: begin out = v % 2;    v = v / 2 + ((v >= 128) ? 128 : 0); end
            3: begin out = v / 128;  v = (v * 2) % 256 + v / 128; end
            4: begin out = v % 2;    v = v / 2 + (v % 2) * 128; end
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic do_load(input int v);
        load = 1'b1; pin = SZ'(v); start = 1'b0;
        @(negedge clk);
        load = 1'b0;
        exp_pout = v;
        checks++; if (pout !== SZ'(v)) $display("FAIL load_pout got=%h exp=%h", pout, SZ'(v)); else passes++;
    endtask

    // Called at a negedge; returns at the negedge where done is seen high.
    // sin_mode: 0 fill 0, 1 fill 1, 2 random. disturb pokes load/start while busy.
    task automatic run_op(input int o, input int k, input int sin_mode, input bit disturb);
        bit valid;
        int eff;
        int s;
        valid = (o <= 2) || (ROT && (o == 3 || o == 4));
        eff = (valid && k > 0) ? k : 0;
        load = 1'b0; start = 1'b1; op = 3'(o); amount = CW'(k);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); amount = CW'($urandom);
        if (eff == 0) begin
            checks++; if (done !== 1'b1) $display("FAIL zero_done op=%0d k=%0d got=%b exp=1", o, k, done); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL zero_busy op=%0d k=%0d got=%b exp=0", o, k, busy); else passes++;
            checks++; if (pout !== SZ'(exp_pout)) $display("FAIL zero_pout got=%h exp=%h", pout, SZ'(exp_pout)); else passes++;
            checks++; if (sout !== 1'(exp_sout)) $display("FAIL zero_sout got=%b exp=%b", sout, 1'(exp_sout)); else passes++;
            @(negedge clk);
            checks++; if (done !== 1'b0) $display("FAIL zero_done_width got=%b exp=0", done); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL zero_busy_after got=%b exp=0", busy); else passes++;
        end else begin
            for (int j = 1; j <= eff; j++) begin
                checks++; if (busy !== 1'b1) $display("FAIL busy_during op=%0d k=%0d cyc=%0d got=%b exp=1", o, k, j, busy); else passes++;
                checks++; if (done !== 1'b0) $display("FAIL done_early op=%0d k=%0d cyc=%0d got=%b exp=0", o, k, j, done); else passes++;
                s = (sin_mode == 2) ? int'($urandom_range(0, 1)) : sin_mode;
                sin = 1'(s);
                if (disturb && j == 1 && eff >= 3) begin
                    load = 1'b1; pin = SZ'($urandom); start = 1'b1;
                end
                if (j == 2) begin
                    load = 1'b0; start = 1'b0;
                end
                @(negedge clk);
                model_step(o, s, exp_pout, exp_sout);
                checks++; if (pout !== SZ'(exp_pout)) $display("FAIL step_pout op=%0d k=%0d cyc=%0d got=%h exp=%h", o, k, j, pout, SZ'(exp_pout)); else passes++;
                checks++; if (sout !== 1'(exp_sout)) $display("FAIL step_sout op=%0d k=%0d cyc=%0d got=%b exp=%b", o, k, j, sout, 1'(exp_sout)); else passes++;
            end
            checks++; if (done !== 1'b1) $display("FAIL done_end op=%0d k=%0d got=%b exp=1", o, k, done); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL busy_end op=%0d k=%0d got=%b exp=0", o, k, busy); else passes++;
        end
    endtask

    task automatic test_reset;
        checks++; if (pout !== 8'h00) $display("FAIL reset_pout got=%h exp=00", pout); else passes++;
        checks++; if (sout !== 1'b0) $display("FAIL reset_sout got=%b exp=0", sout); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
    endtask

    task automatic test_reset_mid_op;
        do_load(8'hFF);
        start = 1'b1; op = 3'd0; amount = CW'(5); sin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (pout !== 8'h00) $display("FAIL midrst_pout got=%h exp=00", pout); else passes++;
        checks++; if (sout !== 1'b0) $display("FAIL midrst_sout got=%b exp=0", sout); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passes++;
        @(negedge clk);
        rst = 1'b0;
        exp_pout = 0; exp_sout = 0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL midrst_no_done cyc=%0d done=%b busy=%b exp=0/0", i, done, busy); else passes++;
            @(negedge clk);
        end
    endtask

    task automatic test_lsl;
        do_load(8'hB4);
        run_op(0, 3, 0, 1'b0);
        checks++; if (pout !== 8'hA0) $display("FAIL lsl_pout got=%h exp=a0", pout); else passes++;
        checks++; if (sout !== 1'b1) $display("FAIL lsl_sout got=%b exp=1", sout); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL lsl_done_width got=%b exp=0", done); else passes++;
    endtask

    task automatic test_asr_lsr;
        do_load(8'h90);
        run_op(2, 2, 0, 1'b0);
        checks++; if (pout !== 8'hE4 || sout !== 1'b0) $display("FAIL asr got=%h/%b exp=e4/0", pout, sout); else passes++;
        @(negedge clk);
        do_load(8'h90);
        run_op(1, 2, 1, 1'b0);
        checks++; if (pout !== 8'hE4 || sout !== 1'b0) $display("FAIL lsr got=%h/%b exp=e4/0", pout, sout); else passes++;
        @(negedge clk);
    endtask

    task automatic test_rotate;
        do_load(8'h81);
`ifdef ROTATE_OPS_EN
        run_op(4, 9, 2, 1'b0);
        checks++; if (pout !== 8'hC0 || sout !== 1'b1) $display("FAIL ror_wrap got=%h/%b exp=c0/1", pout, sout); else passes++;
`else
        run_op(3, 2, 2, 1'b0);
        checks++; if (pout !== 8'h81) $display("FAIL rol_disabled got=%h exp=81", pout); else passes++;
`endif
        @(negedge clk);
    endtask

    task automatic test_handshake;
        do_load(8'h3C);
        run_op(0, 0, 2, 1'b0);
        checks++; if (pout !== 8'h3C) $display("FAIL amount0_pout got=%h exp=3c", pout); else passes++;
        // load and start together: load wins, no done, no busy
        load = 1'b1; pin = 8'h5A; start = 1'b1; op = 3'd0; amount = CW'(3);
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        exp_pout = 8'h5A;
        checks++; if (pout !== 8'h5A) $display("FAIL loadwin_pout got=%h exp=5a", pout); else passes++;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL loadwin_hs busy=%b done=%b exp=0/0", busy, done); else passes++;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL loadwin_hs2 busy=%b done=%b exp=0/0", busy, done); else passes++;
        // load/start while busy are ignored
        run_op(1, 6, 2, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        do_load(8'hC3);
        run_op(0, 2, 2, 1'b0);
        run_op(2, 3, 2, 1'b0);
        run_op(1, 0, 2, 1'b0);
        run_op(1, 4, 2, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) do_load(int'($urandom_range(0, 255)));
            run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_reset_mid_op;
        test_lsl;
        test_asr_lsr;
        test_rotate;
        test_handshake;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/barrel_seq_shifter.md
# barrel_seq_shifter

Parametrised sequential shift unit, the next generation of the datapath shift register. It adds parallel load, a multi-cycle shift by a programmable amount, and logical, arithmetic and rotate operations. It has a per-cycle serial fill input, a shifted-out bit, and a start/busy/done handshake. The controller FSM uses it for operand normalisation and serial data streaming.

## Interface
- SIZE, 10, register width in bits (≥2)
- CNT_W, 4, width of shift-amount input; max amount 2^CNT_W−1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- load  input  1  parallel load request (honoured only when idle)
- pin  input  SIZE  parallel load data
- start  input  1  begin shift operation (honoured only when idle)
- op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 reserved
- amount  input  CNT_W  number of single-bit shifts to perform
- sin  input  1  serial fill bit for LSL/LSR, sampled every shift cycle
- pout  output  SIZE  register contents
- sout  output  1  last bit shifted out of the register
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT.
- IDLE with load=1: pout←pin at next edge. load has priority over start; a start in the same cycle is dropped.
- IDLE with start=1, load=0:
  - If amount=0 or op is reserved (or disabled, see Configuration): no shift. done pulses at the next edge and the FSM stays IDLE.
  - Otherwise op is latched and counter←amount, and the FSM moves to SHIFT.
- SHIFT: one single-bit shift per cycle, counter decrements. After the shift where the counter hits 0, the FSM returns to IDLE.
  - LSL: {pout[SIZE-2:0], sin}, sout←pout[SIZE-1]
  - LSR: {sin, pout[SIZE-1:1]}, sout←pout[0]
  - ASR: {pout[SIZE-1], pout[SIZE-1:1]}, sout←pout[0]
  - ROL: {pout[SIZE-2:0], pout[SIZE-1]}, sout←pout[SIZE-1]
  - ROR: {pout[0], pout[SIZE-1:1]}, sout←pout[0]
- Amount greater than SIZE is legal and performs exactly `amount` steps: logical shifts saturate to the fill pattern, rotates wrap modulo SIZE.
- While busy, load, start, op and amount are ignored. sin is still sampled every shift cycle.
- sout changes only on shift cycles and holds otherwise.

## Timing
- Reset: pout=0, sout=0, busy=0, done=0, FSM=IDLE, counter=0. Reset is asynchronous, so asserting it mid-shift aborts immediately and no done pulse is issued.
- Start sampled at edge E0 with amount k>0:
  - busy=1 from E0 to Ek.
  - pout/sout update at edges E1..Ek.
  - busy falls and done=1 at Ek, for exactly one cycle.
  - Total latency is k cycles.
- Zero-length start: done=1 for one cycle after E0, and busy stays 0.
- A new start is accepted in the cycle done is high, so back-to-back operations are possible with no gap.
- A load occurs one cycle after it is sampled; pout is visible after that edge.

## Configuration
- ROTATE_OPS_EN defined: ROL/ROR are implemented as above.
- ROTATE_OPS_EN undefined: op 011/100 are treated as reserved. They give a zero-length done pulse with pout and sout unchanged, and no rotate logic is synthesised.

## Test plan
- Reset mid-operation: with SIZE=8, load 0xFF, start LSL amount 5, assert rst after 2 cycles → pout=0, sout=0, busy=0, and no done pulse.
- LSL: SIZE=8, load 0xB4, start LSL amount 3, sin=0 → busy for 3 cycles, then pout=0xA0, sout=1, and a single done pulse.
- ASR: load 0x90, start ASR amount 2 → pout=0xE4, sout=0. Repeat with LSR and sin=1 → pout=0xE4, sout=0.
- ROR with wrap: load 0x81, start ROR amount 9 → done after 9 cycles, pout=0xC0, sout=1.
- Handshake corners:
  - amount 0 → done the next cycle, pout unchanged, busy never high.
  - start/load while busy → ignored.
  - load and start together in IDLE → load wins.
  - New start in the done cycle → accepted.
- With ROTATE_OPS_EN undefined: load 0x81, start ROL amount 2 → done after 1 cycle, pout=0x81, busy=0.
